// File: rtl/wasm_pkg.sv
// Shared constants and parser state encoding for the boot-time WebAssembly image loader.
package wasm_pkg;

  localparam int unsigned START_ADDR_DEF = 8;
  localparam int unsigned ROM_SIZE_DEF   = 256;
  localparam logic [7:0]  SEC_CODE       = 8'd10;

  typedef enum logic [3:0] {
    ST_SEC_ID      = 4'd0,
    ST_SEC_SIZE    = 4'd1,
    ST_SKIP        = 4'd2,
    ST_CODE_COUNT  = 4'd3,
    ST_BODY_SIZE   = 4'd4,
    ST_LOCAL_COUNT = 4'd5,
    ST_LOCAL_N     = 4'd6,
    ST_LOCAL_TYPE  = 4'd7,
    ST_COPY        = 4'd8,
    ST_FLUSH       = 4'd9,
    ST_DONE        = 4'd10
  } state_t;

endpackage

// File: rtl/wasm_leb128.sv
// Incremental unsigned LEB128 decoder, one byte per byte_valid, up to 5 bytes into 32 bits.
module wasm_leb128 (
  input  logic        clk,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  data_byte,
  output logic [31:0] value,
  output logic        done
);

  logic [2:0]  idx;
  logic [31:0] acc;
  logic [4:0]  shamt;

  // The accumulator is ignored on the first byte of a field, so it never needs clearing.
  assign shamt = {2'b00, idx} * 5'd7;
  assign value = ((idx == 3'd0) ? 32'd0 : acc) | ({25'd0, data_byte[6:0]} << shamt);
  assign done  = byte_valid & (~data_byte[7] | (idx == 3'd4));

  always_ff @(posedge clk) begin
    if (clr) begin
      idx <= 3'd0;
    end else if (byte_valid) begin
      idx <= done ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) begin
      acc <= value;
    end
  end

endmodule

// File: rtl/wasm.sv
// Boot loader: copies the .wasm image from ROM into memory, finds function 0's first
// opcode, then releases the memory bus and raises rom_mapped.
module wasm
  import wasm_pkg::*;
#(
  parameter int unsigned ROM_SIZE   = ROM_SIZE_DEF,
  parameter int unsigned START_ADDR = START_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      rom_addr,
  input  logic [7:0]       rom_data_out,
  output logic             rom_read_en,
  input  logic             rom_ready,
  output wire logic [31:0] mem_addr,
  output wire logic [7:0]  mem_data_in,
  output wire logic        memory_write_en,
  output logic             rom_mapped,
  output logic [31:0]      first_instruction
);

  state_t      state, state_nxt;
  logic        capture;
  logic [32:0] addr_nxt;
  logic [7:0]  sec_id;
  logic [32:0] sec_end, sec_end_nxt;
  logic [31:0] local_left, local_left_nxt;
  logic        fi_set;
  logic        in_code;
  logic        leb_feed, leb_done;
  logic [31:0] leb_value;
  logic        vld_p1;
  logic [31:0] mem_addr_p1;
  logic [7:0]  mem_data_p1;

  assign capture  = rom_read_en & rom_ready;
  assign addr_nxt = {1'b0, rom_addr} + 33'd1;
  assign in_code  = (state == ST_CODE_COUNT) || (state == ST_BODY_SIZE) ||
                    (state == ST_LOCAL_COUNT) || (state == ST_LOCAL_N) ||
                    (state == ST_LOCAL_TYPE) || (state == ST_COPY);
  assign leb_feed = capture && ((state == ST_SEC_SIZE) || (state == ST_CODE_COUNT) ||
                    (state == ST_BODY_SIZE) || (state == ST_LOCAL_COUNT) ||
                    (state == ST_LOCAL_N));

  wasm_leb128 u_leb (
    .clk        (clk),
    .clr        (rst),
    .byte_valid (leb_feed),
    .data_byte  (rom_data_out),
    .value      (leb_value),
    .done       (leb_done)
  );

  always_comb begin
    state_nxt      = state;
    sec_end_nxt    = sec_end;
    local_left_nxt = local_left;
    fi_set         = 1'b0;
    if (capture) begin
      case (state)
        ST_SEC_ID: state_nxt = ST_SEC_SIZE;
        ST_SEC_SIZE: begin
          if (leb_done) begin
            sec_end_nxt = addr_nxt + {1'b0, leb_value};
            if (sec_id == SEC_CODE) begin
              state_nxt = (leb_value == 32'd0) ? ST_FLUSH : ST_CODE_COUNT;
            end else begin
              state_nxt = (leb_value == 32'd0) ? ST_SEC_ID : ST_SKIP;
            end
          end
        end
        ST_SKIP: if (addr_nxt >= sec_end) state_nxt = ST_SEC_ID;
        ST_CODE_COUNT: if (leb_done) state_nxt = ST_BODY_SIZE;
        ST_BODY_SIZE: if (leb_done) state_nxt = ST_LOCAL_COUNT;
        ST_LOCAL_COUNT: begin
          if (leb_done) begin
            if (leb_value == 32'd0) begin
              fi_set    = 1'b1;
              state_nxt = ST_COPY;
            end else begin
              local_left_nxt = leb_value;
              state_nxt      = ST_LOCAL_N;
            end
          end
        end
        ST_LOCAL_N: if (leb_done) state_nxt = ST_LOCAL_TYPE;
        ST_LOCAL_TYPE: begin
          local_left_nxt = local_left - 32'd1;
          if (local_left == 32'd1) begin
            fi_set    = 1'b1;
            state_nxt = ST_COPY;
          end else begin
            state_nxt = ST_LOCAL_N;
          end
        end
        default: ;
      endcase
      // Section end and ROM end both stop reading; the captured byte still gets written.
      if (in_code && (addr_nxt >= sec_end)) state_nxt = ST_FLUSH;
      if (addr_nxt >= 33'(ROM_SIZE)) state_nxt = ST_FLUSH;
    end else if (state == ST_FLUSH) begin
      state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_SEC_ID;
      rom_addr          <= START_ADDR;
      rom_read_en       <= 1'b0;
      rom_mapped        <= 1'b0;
      first_instruction <= 32'd0;
      vld_p1            <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_read_en <= (state_nxt != ST_FLUSH) && (state_nxt != ST_DONE);
      vld_p1      <= capture;
      if (capture) rom_addr <= addr_nxt[31:0];
      if (fi_set) first_instruction <= addr_nxt[31:0];
      if (state_nxt == ST_DONE) rom_mapped <= 1'b1;
    end
  end

  // p1: captured byte becomes a one-cycle memory write
  always_ff @(posedge clk) begin
    sec_end    <= sec_end_nxt;
    local_left <= local_left_nxt;
    if (capture && (state == ST_SEC_ID)) sec_id <= rom_data_out;
    if (capture) begin
      mem_addr_p1 <= rom_addr;
      mem_data_p1 <= rom_data_out;
    end
  end

  assign mem_addr        = rom_mapped ? 32'bz : mem_addr_p1;
  assign mem_data_in     = rom_mapped ? 8'bz  : mem_data_p1;
  assign memory_write_en = rom_mapped ? 1'bz  : vld_p1;

endmodule

// File: tb/tb_wasm.sv
// Directed bench for the wasm loader: ROM responder, memory model and vector table.
module tb_wasm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [7:0]  rom_data_out;
  logic        rom_read_en;
  logic        rom_ready;
  wire  [31:0] mem_addr;
  wire  [7:0]  mem_data_in;
  wire         memory_write_en;
  logic        rom_mapped;
  logic [31:0] first_instruction;
  logic        drv;
  logic        mem_clr;

  logic [7:0]  rom [256];
  logic [7:0]  mem [256];
  logic [31:0] served;
  int          wr_count;
  int          passed = 0;
  int          total  = 0;

  typedef struct {
    int          img;
    logic [31:0] exp_fi;
    logic [31:0] exp_end;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  assign mem_addr    = drv ? 32'h0000_00AB : 32'bz;
  assign mem_data_in = drv ? 8'h5A : 8'bz;

  wasm dut (
    .clk               (clk),
    .rst               (rst),
    .rom_addr          (rom_addr),
    .rom_data_out      (rom_data_out),
    .rom_read_en       (rom_read_en),
    .rom_ready         (rom_ready),
    .mem_addr          (mem_addr),
    .mem_data_in       (mem_data_in),
    .memory_write_en   (memory_write_en),
    .rom_mapped        (rom_mapped),
    .first_instruction (first_instruction)
  );

  // ROM answers once per new address, one cycle after the request
  always @(posedge clk) begin
    if (rst) begin
      rom_ready <= 1'b0;
      served    <= 32'hFFFF_FFFF;
    end else if (rom_read_en && (rom_addr != served)) begin
      rom_ready    <= 1'b1;
      rom_data_out <= rom[rom_addr[7:0]];
      served       <= rom_addr;
    end else begin
      rom_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      wr_count <= 0;
    end else if (memory_write_en === 1'b1) begin
      mem[mem_addr[7:0]] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_image(input int k);
    for (int i = 0; i < 256; i++) rom[i] = (k == 7) ? 8'h00 : ((k == 6) ? 8'h33 : 8'hC3);
    case (k)
      1: begin
        rom[8'h08] = 8'h0A; rom[8'h09] = 8'h04; rom[8'h0A] = 8'h01;
        rom[8'h0B] = 8'h02; rom[8'h0C] = 8'h00; rom[8'h0D] = 8'h0B;
      end
      2: begin
        rom[8'h08] = 8'h01; rom[8'h09] = 8'h05; rom[8'h0A] = 8'h60; rom[8'h0B] = 8'h00;
        rom[8'h0C] = 8'h00; rom[8'h0D] = 8'h00; rom[8'h0E] = 8'h00;
        rom[8'h0F] = 8'h0A; rom[8'h10] = 8'h04; rom[8'h11] = 8'h01;
        rom[8'h12] = 8'h02; rom[8'h13] = 8'h00; rom[8'h14] = 8'h0B;
      end
      3: begin
        rom[8'h08] = 8'h0A; rom[8'h09] = 8'h07; rom[8'h0A] = 8'h01; rom[8'h0B] = 8'h05;
        rom[8'h0C] = 8'h01; rom[8'h0D] = 8'h02; rom[8'h0E] = 8'h7F; rom[8'h0F] = 8'h0B;
        rom[8'h10] = 8'h0B;
      end
      4: begin
        rom[8'h08] = 8'h00; rom[8'h09] = 8'h80; rom[8'h0A] = 8'h01;
        for (int i = 0; i < 128; i++) rom[8'h0B + i] = 8'(i * 3);
        rom[8'h8B] = 8'h0A; rom[8'h8C] = 8'h04; rom[8'h8D] = 8'h01;
        rom[8'h8E] = 8'h02; rom[8'h8F] = 8'h00; rom[8'h90] = 8'h0B;
      end
      5: begin
        rom[8'h08] = 8'h0A; rom[8'h09] = 8'h84; rom[8'h0A] = 8'h80; rom[8'h0B] = 8'h80;
        rom[8'h0C] = 8'h80; rom[8'h0D] = 8'h70; rom[8'h0E] = 8'h01; rom[8'h0F] = 8'h02;
        rom[8'h10] = 8'h00; rom[8'h11] = 8'h0B;
      end
      6: begin
        rom[8'h08] = 8'h00; rom[8'h09] = 8'hF6; rom[8'h0A] = 8'h01;
      end
      default: ;
    endcase
  endtask

  task automatic start_load();
    rst = 1'b1; mem_clr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rom_mapped === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int mem_errs(input int end_a);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== (((i >= 8) && (i < end_a)) ? rom[i] : 8'hEE)) n++;
    end
    return n;
  endfunction

  initial begin
    bit ok;
    bit seen;
    rst = 1'b1; drv = 1'b0; mem_clr = 1'b1;
    vecs[0] = '{1, 32'h0D, 32'h0E};
    vecs[1] = '{2, 32'h14, 32'h15};
    vecs[2] = '{3, 32'h0F, 32'h11};
    vecs[3] = '{4, 32'h90, 32'h91};
    vecs[4] = '{5, 32'h11, 32'h12};
    vecs[5] = '{6, 32'h00, 32'h100};
    vecs[6] = '{7, 32'h00, 32'h100};

    // Reset values, then exact timing of the final write and bus release
    load_image(1);
    @(posedge clk); #1;
    check32("rst_rom_addr", rom_addr, 32'd8);
    check32("rst_read_en", {31'd0, rom_read_en}, 32'd0);
    check32("rst_write_en", {31'd0, memory_write_en}, 32'd0);
    check32("rst_mapped", {31'd0, rom_mapped}, 32'd0);
    check32("rst_first_instr", first_instruction, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((memory_write_en === 1'b1) && (mem_addr === 32'h0D)) begin
        seen = 1'b1;
        check32("mapped_before_last_write", {31'd0, rom_mapped}, 32'd0);
        break;
      end
    end
    check32("last_write_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check32("mapped_after_last_write", {31'd0, rom_mapped}, 32'd1);
    check32("first_instr_t1", first_instruction, 32'h0D);
    drv = 1'b1;
    repeat (3) @(negedge clk);
    check32("release_mem_addr", mem_addr, 32'hAB);
    check32("release_mem_data", {24'd0, mem_data_in}, 32'h5A);
    check32("release_write_en", {31'd0, (memory_write_en === 1'b1)}, 32'd0);
    check32("release_read_en", {31'd0, rom_read_en}, 32'd0);
    check32("release_mapped_sticky", {31'd0, rom_mapped}, 32'd1);
    check32("release_rom_addr", rom_addr, 32'h0E);
    drv = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_image(vecs[v].img);
      start_load();
      wait_done(ok);
      check32($sformatf("img%0d_done", vecs[v].img), {31'd0, ok}, 32'd1);
      check32($sformatf("img%0d_first_instr", vecs[v].img), first_instruction, vecs[v].exp_fi);
      check32($sformatf("img%0d_rom_addr", vecs[v].img), rom_addr, vecs[v].exp_end);
      check32($sformatf("img%0d_read_en", vecs[v].img), {31'd0, rom_read_en}, 32'd0);
      check32($sformatf("img%0d_write_count", vecs[v].img), wr_count, vecs[v].exp_end - 32'd8);
      check32($sformatf("img%0d_mem_errs", vecs[v].img), mem_errs(int'(vecs[v].exp_end)), 32'd0);
    end

    // Reset in the middle of a load restarts it without clearing memory
    load_image(4);
    start_load();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midrst_rom_addr", rom_addr, 32'd8);
    check32("midrst_mapped", {31'd0, rom_mapped}, 32'd0);
    rst = 1'b0;
    wait_done(ok);
    check32("midrst_done", {31'd0, ok}, 32'd1);
    check32("midrst_first_instr", first_instruction, 32'h90);
    check32("midrst_rom_addr_end", rom_addr, 32'h91);
    check32("midrst_mem_errs", mem_errs(32'h91), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
